// File: rtl/alu_reg_pipe.sv
// alu_reg_pipe: registered two-operand ALU with NZCV flags, start/busy/done
// handshake (one op in flight) and optional accumulate write-back into A.
`default_nettype none

module alu_reg_pipe #(
  parameter int WIDTH  = 8,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             a_ld,
  input  logic             b_ld,
  input  logic             a_clr,
  input  logic             b_clr,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             acc,
  input  logic             out_en,
  output logic [WIDTH-1:0] s_out,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] stg_a, stg_b;
  logic [2:0]       stg_op;
  logic             stg_acc;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags_reg;
  logic             done_reg;
  logic             accept;
  logic             acc_wb;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // Handshake FSM: IDLE accepts a start, EXEC is the single compute cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = EXEC;
      end
      EXEC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == EXEC);

  generate
    if (ACC_EN) begin : g_acc_on
      assign acc_wb = busy & stg_acc;
    end else begin : g_acc_off
      assign acc_wb = 1'b0;
    end
  endgenerate

  // Function unit works off the stage registers so operand loads during busy
  // cannot disturb the in-flight op.
  always_comb begin
    sum     = {1'b0, stg_a} + {1'b0, stg_b};
    diff    = {1'b0, stg_a} - {1'b0, stg_b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (stg_op)
      3'b000: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (stg_a[MSB] == stg_b[MSB]) && (sum[MSB] != stg_a[MSB]);
      end
      3'b001: begin
        alu_res = diff[MSB:0];
        alu_c   = diff[WIDTH];
        alu_v   = (stg_a[MSB] != stg_b[MSB]) && (diff[MSB] != stg_a[MSB]);
      end
      3'b010: alu_res = stg_a & stg_b;
      3'b011: alu_res = stg_a | stg_b;
      3'b100: alu_res = stg_a ^ stg_b;
      3'b101: alu_res = stg_a;
      3'b110: begin
        alu_res = {stg_a[MSB-1:0], 1'b0};
        alu_c   = stg_a[MSB];
      end
      default: begin
        alu_res = {1'b0, stg_a[MSB:1]};
        alu_c   = stg_a[0];
      end
    endcase
  end

  // Accumulate write-back outranks a_ld/a_clr on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (acc_wb)     a_reg <= alu_res;
      else if (a_ld)  a_reg <= a_in;
      else if (a_clr) a_reg <= '0;
      if (b_ld)       b_reg <= b_in;
      else if (b_clr) b_reg <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_a     <= '0;
      stg_b     <= '0;
      stg_op    <= '0;
      stg_acc   <= 1'b0;
      result    <= '0;
      flags_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= busy;
      if (accept) begin
        stg_a   <= a_reg;
        stg_b   <= b_reg;
        stg_op  <= op;
        stg_acc <= acc;
      end
      if (busy) begin
        result    <= alu_res;
        flags_reg <= {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
      end
    end
  end

  assign s_out = out_en ? result : '0;
  assign flags = flags_reg;
  assign done  = done_reg;

endmodule

`default_nettype wire

// File: tb/tb_alu_reg_pipe.sv
// Self-checking bench for alu_reg_pipe (WIDTH=8, ACC_EN=1): vector table plus
// hand-written reset, out_en, accumulate and abort sequences.
`default_nettype none

module tb_alu_reg_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_in, b_in;
  logic       a_ld, b_ld, a_clr, b_clr;
  logic [2:0] op;
  logic       start, acc, out_en;
  logic [7:0] s_out;
  logic [3:0] flags;
  logic       busy, done;

  int passed = 0;
  int total  = 0;

  alu_reg_pipe #(.WIDTH(8), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in),
    .a_ld(a_ld), .b_ld(b_ld), .a_clr(a_clr), .b_clr(b_clr),
    .op(op), .start(start), .acc(acc), .out_en(out_en),
    .s_out(s_out), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;   // {N,Z,C,V}
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads A/B, issues one op, checks busy/done timing and the result/flags.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic [3:0] fl);
    a_in = a; b_in = b; a_ld = 1'b1; b_ld = 1'b1;
    step();
    a_ld = 1'b0; b_ld = 1'b0; op = f; start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, " busy@T"}, busy, 1'b1);
    step();
    chk({nm, " done@T+1"}, done, 1'b1);
    chk({nm, " s_out"}, s_out, res);
    chk({nm, " flags"}, flags, fl);
    step();
    chk({nm, " done cleared"}, done, 1'b0);
  endtask

  initial begin
    int dcount;

    vecs[0]  = '{"add_ovf",  3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001};
    vecs[1]  = '{"sub_brw",  3'b001, 8'h10, 8'h20, 8'hF0, 4'b1010};
    vecs[2]  = '{"shl",      3'b110, 8'h81, 8'h00, 8'h02, 4'b0010};
    vecs[3]  = '{"xor_zero", 3'b100, 8'h5A, 8'h5A, 8'h00, 4'b0100};
    vecs[4]  = '{"shr_c",    3'b111, 8'h01, 8'h00, 8'h00, 4'b0110};
    vecs[5]  = '{"and",      3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[6]  = '{"or",       3'b011, 8'h0F, 8'h80, 8'h8F, 4'b1000};
    vecs[7]  = '{"pass_a",   3'b101, 8'h00, 8'hFF, 8'h00, 4'b0100};
    vecs[8]  = '{"add_wrap", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b0110};
    vecs[9]  = '{"sub_ovf",  3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[10] = '{"shr_msb",  3'b111, 8'h80, 8'h00, 8'h40, 4'b0000};

    // Reset held with every input active.
    rst_n = 1'b0; a_in = 8'hAA; b_in = 8'h55; a_ld = 1'b1; b_ld = 1'b1;
    a_clr = 1'b1; b_clr = 1'b1; op = 3'b000; start = 1'b1; acc = 1'b1; out_en = 1'b1;
    step(); step();
    chk("rst s_out", s_out, 8'h00);
    chk("rst flags", flags, 4'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);

    rst_n = 1'b1; a_ld = 1'b0; b_ld = 1'b0; a_clr = 1'b0; b_clr = 1'b0; acc = 1'b0;
    step();
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dcount++;
    end
    chk("post-rst single done", dcount, 1);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl);

    // out_en gates s_out combinationally but never the flags.
    out_en = 1'b0;
    a_in = 8'h10; b_in = 8'h20; a_ld = 1'b1; b_ld = 1'b1;
    step();
    a_ld = 1'b0; b_ld = 1'b0; op = 3'b001; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("gate done", done, 1'b1);
    chk("gate s_out off", s_out, 8'h00);
    chk("gate flags", flags, 4'b1010);
    out_en = 1'b1;
    #1;
    chk("gate s_out on", s_out, 8'hF0);
    step();

    // Accumulate with start held high: ops every 2 cycles; a_ld on the
    // final write-back edge must lose to the accumulate.
    a_in = 8'h05; b_in = 8'h03; a_ld = 1'b1; b_ld = 1'b1;
    step();
    a_ld = 1'b0; b_ld = 1'b0; op = 3'b000; acc = 1'b1; start = 1'b1;
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("acc%0d busy", i), busy, 1'b1);
      if (done) dcount++;
      if (i == 2) begin a_in = 8'hFF; a_ld = 1'b1; end
      step();
      a_ld = 1'b0;
      if (done) dcount++;
      chk($sformatf("acc%0d s_out", i), s_out, 8'h08 + 8'(3 * i));
      if (i == 2) start = 1'b0;
    end
    step();
    if (done) dcount++;
    chk("acc done count", dcount, 3);
    chk("acc idle", busy, 1'b0);
    acc = 1'b0;
    op = 3'b101; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("acc final A", s_out, 8'h0E);
    step();

    // Reset in the middle of an op: aborted, no done, all state cleared.
    a_in = 8'h05; b_in = 8'h03; a_ld = 1'b1; b_ld = 1'b1;
    step();
    a_ld = 1'b0; b_ld = 1'b0; op = 3'b000; start = 1'b1;
    step();
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    dcount = 0;
    step();
    if (done) dcount++;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (done) dcount++;
    end
    chk("abort no done", dcount, 0);
    chk("abort s_out", s_out, 8'h00);
    chk("abort flags", flags, 4'h0);
    op = 3'b000; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("abort A+B", s_out, 8'h00);
    chk("abort A+B flags", flags, 4'b0100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
